// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch/decode/execute Moore FSM driving datapath strobes.
// Optional mul/div execution is built only when CONTROL_SEQUENCER_MULDIV_EN is defined.
module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [15:0] gpr_in,
    output logic [15:0] gpr_out,
    output logic        pc_in,
    output logic        pc_out,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        z_low_out,
    output logic        z_high_out,
    output logic        hi_in,
    output logic        hi_out,
    output logic        lo_in,
    output logic        lo_out,
    output logic        c_out,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        read,
    output logic        inc_pc,
    output logic [3:0]  alu_op,
    output logic        run,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        C_REG, C_IMM, C_UNARY, C_NOP, C_HALT, C_MULDIV, C_UNDEF
    } op_class_t;

    state_t     cur, nxt;
    op_class_t  op_class;
    logic [3:0] op_alu;
    logic       illegal_q, illegal_d;
    logic [15:0] ra_hot, rb_hot, rc_hot;
    logic       unused_ir;

    assign ra_hot    = 16'd1 << ir[26:23];
    assign rb_hot    = 16'd1 << ir[22:19];
    assign rc_hot    = 16'd1 << ir[18:15];
    assign unused_ir = ^ir[14:0];
    assign state     = cur;
    assign hi_out    = 1'b0;
    assign lo_out    = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= S_RESET;
            illegal_q <= 1'b0;
        end else begin
            cur       <= nxt;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        op_class = C_UNDEF;
        op_alu   = 4'b0000;
        case (ir[31:27])
            5'b00011: begin op_class = C_REG;   op_alu = 4'b0010; end
            5'b00100: begin op_class = C_REG;   op_alu = 4'b0011; end
            5'b00101: begin op_class = C_REG;   op_alu = 4'b0100; end
            5'b00110: begin op_class = C_REG;   op_alu = 4'b0101; end
            5'b00111: begin op_class = C_REG;   op_alu = 4'b0110; end
            5'b01000: begin op_class = C_REG;   op_alu = 4'b0111; end
            5'b01001: begin op_class = C_REG;   op_alu = 4'b0000; end
            5'b01010: begin op_class = C_REG;   op_alu = 4'b0001; end
            5'b01011: begin op_class = C_IMM;   op_alu = 4'b0010; end
            5'b01100: begin op_class = C_IMM;   op_alu = 4'b0000; end
            5'b01101: begin op_class = C_IMM;   op_alu = 4'b0001; end
`ifdef CONTROL_SEQUENCER_MULDIV_EN
            5'b01110: begin op_class = C_MULDIV; op_alu = 4'b1000; end
            5'b01111: begin op_class = C_MULDIV; op_alu = 4'b1001; end
`endif
            5'b10000: begin op_class = C_UNARY; op_alu = 4'b1010; end
            5'b10001: begin op_class = C_UNARY; op_alu = 4'b1011; end
            5'b11010: op_class = C_NOP;
            5'b11011: op_class = C_HALT;
            default:  op_class = C_UNDEF;
        endcase
    end

    always_comb begin
        nxt        = cur;
        illegal_d  = illegal_q;
        gpr_in     = 16'h0000;
        gpr_out    = 16'h0000;
        pc_in      = 1'b0;
        pc_out     = 1'b0;
        ir_in      = 1'b0;
        y_in       = 1'b0;
        z_in       = 1'b0;
        z_low_out  = 1'b0;
        z_high_out = 1'b0;
        hi_in      = 1'b0;
        lo_in      = 1'b0;
        c_out      = 1'b0;
        mar_in     = 1'b0;
        mdr_in     = 1'b0;
        mdr_out    = 1'b0;
        read       = 1'b0;
        inc_pc     = 1'b0;
        alu_op     = 4'b0000;
        run        = (cur != S_RESET) && (cur != S_HALT);
        illegal    = (cur == S_HALT) && illegal_q;
        case (cur)
            S_RESET: nxt = S_T0;
            S_T0: begin
                pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
                alu_op = 4'b0010;
                nxt    = S_T1;
            end
            S_T1: begin
                z_low_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1;
                nxt       = mem_ready ? S_T2 : S_T1;
            end
            S_T2: begin
                mdr_out = 1'b1; ir_in = 1'b1;
                nxt     = S_T3;
            end
            S_T3: begin
                case (op_class)
                    C_REG, C_IMM: begin
                        gpr_out = rb_hot; y_in = 1'b1; nxt = S_T4;
                    end
                    C_UNARY: begin
                        gpr_out = rb_hot; z_in = 1'b1; alu_op = op_alu; nxt = S_T4;
                    end
                    C_MULDIV: begin
                        gpr_out = ra_hot; y_in = 1'b1; nxt = S_T4;
                    end
                    C_NOP:  nxt = S_T0;
                    C_HALT: begin nxt = S_HALT; illegal_d = 1'b0; end
                    default: begin nxt = S_HALT; illegal_d = 1'b1; end
                endcase
            end
            S_T4: begin
                // Unary ops write back here; binary ops compute into Z.
                case (op_class)
                    C_UNARY: begin
                        z_low_out = 1'b1; gpr_in = ra_hot; nxt = S_T0;
                    end
                    C_IMM: begin
                        c_out = 1'b1; z_in = 1'b1; alu_op = op_alu; nxt = S_T5;
                    end
                    C_MULDIV: begin
                        gpr_out = rb_hot; z_in = 1'b1; alu_op = op_alu; nxt = S_T5;
                    end
                    default: begin
                        gpr_out = rc_hot; z_in = 1'b1; alu_op = op_alu; nxt = S_T5;
                    end
                endcase
            end
            S_T5: begin
                z_low_out = 1'b1;
                nxt       = S_T0;
`ifdef CONTROL_SEQUENCER_MULDIV_EN
                if (op_class == C_MULDIV) begin
                    lo_in = 1'b1; nxt = S_T6;
                end else begin
                    gpr_in = ra_hot;
                end
`else
                gpr_in = ra_hot;
`endif
            end
            S_T6: begin
`ifdef CONTROL_SEQUENCER_MULDIV_EN
                z_high_out = 1'b1; hi_in = 1'b1;
`endif
                nxt = S_T0;
            end
            S_HALT:  nxt = S_HALT;
            default: nxt = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer: fetch, wait states, every
// instruction class, halt/illegal, and reset from mid-execution and from HALT.
module tb_control_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] ir;
    logic        mem_ready;
    logic [15:0] gpr_in, gpr_out;
    logic        pc_in, pc_out, ir_in, y_in, z_in, z_low_out, z_high_out;
    logic        hi_in, hi_out, lo_in, lo_out, c_out, mar_in, mdr_in, mdr_out;
    logic        read, inc_pc, run, illegal;
    logic [3:0]  alu_op, state;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [3:0] ST_RESET = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T2 = 4'd3,
                           ST_T3 = 4'd4, ST_T4 = 4'd5, ST_T5 = 4'd6, ST_T6 = 4'd7,
                           ST_HALT = 4'd8;

    localparam logic [16:0] PC_IN = 17'd1 << 16, PC_OUT = 17'd1 << 15, IR_IN = 17'd1 << 14,
                            Y_IN = 17'd1 << 13, Z_IN = 17'd1 << 12, Z_LOW_OUT = 17'd1 << 11,
                            Z_HIGH_OUT = 17'd1 << 10, HI_IN = 17'd1 << 9, HI_OUT = 17'd1 << 8,
                            LO_IN = 17'd1 << 7, LO_OUT = 17'd1 << 6, C_OUT = 17'd1 << 5,
                            MAR_IN = 17'd1 << 4, MDR_IN = 17'd1 << 3, MDR_OUT = 17'd1 << 2,
                            READ = 17'd1 << 1, INC_PC = 17'd1;

    logic [16:0] strobes;
    assign strobes = {pc_in, pc_out, ir_in, y_in, z_in, z_low_out, z_high_out, hi_in, hi_out,
                      lo_in, lo_out, c_out, mar_in, mdr_in, mdr_out, read, inc_pc};

    control_sequencer dut (
        .clk(clk), .reset(reset), .ir(ir), .mem_ready(mem_ready),
        .gpr_in(gpr_in), .gpr_out(gpr_out),
        .pc_in(pc_in), .pc_out(pc_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
        .z_low_out(z_low_out), .z_high_out(z_high_out), .hi_in(hi_in), .hi_out(hi_out),
        .lo_in(lo_in), .lo_out(lo_out), .c_out(c_out), .mar_in(mar_in), .mdr_in(mdr_in),
        .mdr_out(mdr_out), .read(read), .inc_pc(inc_pc), .alu_op(alu_op),
        .run(run), .illegal(illegal), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout state=%0d", state);
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] st, input logic [16:0] strb,
                              input logic [15:0] gin, input logic [15:0] gout,
                              input logic [3:0] alu, input logic rn, input logic ill);
        check({tag, ".state"},   32'(state),   32'(st));
        check({tag, ".strobes"}, 32'(strobes), 32'(strb));
        check({tag, ".gpr_in"},  32'(gpr_in),  32'(gin));
        check({tag, ".gpr_out"}, 32'(gpr_out), 32'(gout));
        check({tag, ".alu_op"},  32'(alu_op),  32'(alu));
        check({tag, ".run"},     32'(run),     32'(rn));
        check({tag, ".illegal"}, 32'(illegal), 32'(ill));
    endtask

    // Resets for one cycle and leaves the FSM in T0.
    task automatic do_reset();
        reset = 1'b1;
        step();
        expect_out("reset", ST_RESET, 17'd0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
    endtask

    // Fetch starting in T0; ir holds junk until the last T1 cycle, then instr.
    task automatic fetch(input string tag, input int waits, input logic [31:0] instr);
        ir        = $urandom;
        mem_ready = (waits == 0);
        expect_out({tag, ".t0"}, ST_T0, PC_OUT | MAR_IN | INC_PC | Z_IN, 16'h0, 16'h0,
                   4'b0010, 1'b1, 1'b0);
        step();
        expect_out({tag, ".t1"}, ST_T1, Z_LOW_OUT | PC_IN | READ | MDR_IN, 16'h0, 16'h0,
                   4'h0, 1'b1, 1'b0);
        for (int i = 0; i < waits; i++) begin
            ir = $urandom;
            step();
            expect_out({tag, ".t1w"}, ST_T1, Z_LOW_OUT | PC_IN | READ | MDR_IN, 16'h0, 16'h0,
                       4'h0, 1'b1, 1'b0);
        end
        mem_ready = 1'b1;
        ir        = instr;
        step();
        expect_out({tag, ".t2"}, ST_T2, MDR_OUT | IR_IN, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        step();
    endtask

    initial begin
        reset     = 1'b1;
        ir        = 32'h0;
        mem_ready = 1'b1;
        step();
        do_reset();

        // and R5,R2,R4
        fetch("and", 0, 32'h4A920000);
        expect_out("and.t3", ST_T3, Y_IN, 16'h0, 16'h0004, 4'h0, 1'b1, 1'b0);
        step();
        expect_out("and.t4", ST_T4, Z_IN, 16'h0, 16'h0010, 4'b0000, 1'b1, 1'b0);
        step();
        expect_out("and.t5", ST_T5, Z_LOW_OUT, 16'h0020, 16'h0, 4'h0, 1'b1, 1'b0);
        step();

        // add R1,R3,R0 with three wait cycles in T1
        fetch("add", 3, 32'h18980000);
        expect_out("add.t3", ST_T3, Y_IN, 16'h0, 16'h0008, 4'h0, 1'b1, 1'b0);
        step();
        expect_out("add.t4", ST_T4, Z_IN, 16'h0, 16'h0001, 4'b0010, 1'b1, 1'b0);
        step();
        expect_out("add.t5", ST_T5, Z_LOW_OUT, 16'h0002, 16'h0, 4'h0, 1'b1, 1'b0);
        step();

        // addi R5,R2,5
        fetch("addi", 0, 32'h5A900005);
        expect_out("addi.t3", ST_T3, Y_IN, 16'h0, 16'h0004, 4'h0, 1'b1, 1'b0);
        step();
        expect_out("addi.t4", ST_T4, C_OUT | Z_IN, 16'h0, 16'h0, 4'b0010, 1'b1, 1'b0);
        step();
        expect_out("addi.t5", ST_T5, Z_LOW_OUT, 16'h0020, 16'h0, 4'h0, 1'b1, 1'b0);
        step();

        // neg R3,R7
        fetch("neg", 1, 32'h81B80000);
        expect_out("neg.t3", ST_T3, Z_IN, 16'h0, 16'h0080, 4'b1010, 1'b1, 1'b0);
        step();
        expect_out("neg.t4", ST_T4, Z_LOW_OUT, 16'h0008, 16'h0, 4'h0, 1'b1, 1'b0);
        step();

        // nop goes straight back to T0
        fetch("nop", 0, 32'hD0000000);
        expect_out("nop.t3", ST_T3, 17'd0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        step();

        // sub R0,R0,R0 interrupted by reset in T4
        fetch("sub", 0, 32'h20000000);
        expect_out("sub.t3", ST_T3, Y_IN, 16'h0, 16'h0001, 4'h0, 1'b1, 1'b0);
        step();
        expect_out("sub.t4", ST_T4, Z_IN, 16'h0, 16'h0001, 4'b0011, 1'b1, 1'b0);
        do_reset();

        // reset during a T1 wait dominates mem_ready
        ir = 32'h0;
        mem_ready = 1'b0;
        step();
        expect_out("t1rst.t1", ST_T1, Z_LOW_OUT | PC_IN | READ | MDR_IN, 16'h0, 16'h0,
                   4'h0, 1'b1, 1'b0);
        mem_ready = 1'b1;
        do_reset();

        // halt: HALT is sticky regardless of ir and mem_ready
        fetch("halt", 0, 32'hD8000000);
        expect_out("halt.t3", ST_T3, 17'd0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        step();
        expect_out("halt.h0", ST_HALT, 17'd0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
        ir = 32'h4A920000;
        mem_ready = 1'b0;
        step();
        step();
        expect_out("halt.h2", ST_HALT, 17'd0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
        mem_ready = 1'b1;
        do_reset();

        // undefined opcode 11111
        fetch("undef", 0, 32'hF8000000);
        step();
        expect_out("undef.h", ST_HALT, 17'd0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b1);
        step();
        expect_out("undef.h1", ST_HALT, 17'd0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b1);
        do_reset();
        expect_out("undef.clr", ST_T0, PC_OUT | MAR_IN | INC_PC | Z_IN, 16'h0, 16'h0,
                   4'b0010, 1'b1, 1'b0);

        // mul R2,R2
        fetch("mul", 0, 32'h71100000);
`ifdef CONTROL_SEQUENCER_MULDIV_EN
        expect_out("mul.t3", ST_T3, Y_IN, 16'h0, 16'h0004, 4'h0, 1'b1, 1'b0);
        step();
        expect_out("mul.t4", ST_T4, Z_IN, 16'h0, 16'h0004, 4'b1000, 1'b1, 1'b0);
        step();
        expect_out("mul.t5", ST_T5, Z_LOW_OUT | LO_IN, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        step();
        expect_out("mul.t6", ST_T6, Z_HIGH_OUT | HI_IN, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        step();
        expect_out("mul.t0", ST_T0, PC_OUT | MAR_IN | INC_PC | Z_IN, 16'h0, 16'h0,
                   4'b0010, 1'b1, 1'b0);
`else
        expect_out("mul.t3", ST_T3, 17'd0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        step();
        expect_out("mul.h", ST_HALT, 17'd0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have: clk  in  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: ir  in  32  datapath IR contents; opcode ir[31:27], ra ir[26:23], rb ir[22:19], rc ir[18:15].
REQ-004 SHALL have: mem_ready  in  1  memory read data valid on m_data_in this cycle.
REQ-005 SHALL have: gpr_in, gpr_out  out  16 each  one-hot register load/drive selects.
REQ-006 SHALL have: pc_in, pc_out, ir_in, y_in, z_in, z_low_out, z_high_out, hi_in, hi_out, lo_in, lo_out, c_out, mar_in, mdr_in, mdr_out, read, inc_pc  out  1 each  datapath strobes.
REQ-007 SHALL have: alu_op  out  4  And 0000, Or 0001, Add 0010, Sub 0011, Shr 0100, Shl 0101, Ror 0110, Rol 0111, Mul 1000, Div 1001, Neg 1010, Not 1011.
REQ-008 SHALL have: run  out  1  high unless in RESET or HALT; illegal  out  1  high in HALT entered via undefined opcode.

Function
REQ-009 SHALL be a Moore FSM; states RESET, T0-T6, HALT; outputs depend only on state and ir; every strobe not listed for a state is 0; alu_op is 0000 unless listed.
REQ-010 SHALL sequence fetch: T0 pc_out, mar_in, inc_pc, z_in, alu_op=Add; T1 z_low_out, pc_in, read, mdr_in; T2 mdr_out, ir_in.
REQ-011 SHALL remain in T1 with T1 outputs held while mem_ready=0; T1->T2 on the first edge with mem_ready=1.
REQ-012 SHALL decode opcodes: add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010, addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, nop 11010, halt 11011; all others undefined.
REQ-013 SHALL execute R-format (add..or): T3 gpr_out[rb], y_in; T4 gpr_out[rc], alu_op, z_in; T5 z_low_out, gpr_in[ra]; T5->T0.
REQ-014 SHALL execute I-format (addi, andi, ori): T3 gpr_out[rb], y_in; T4 c_out, z_in, alu_op Add/And/Or; T5 z_low_out, gpr_in[ra]; T5->T0.
REQ-015 SHALL execute neg/not: T3 gpr_out[rb], z_in, alu_op Neg/Not; T4 z_low_out, gpr_in[ra]; T4->T0.
REQ-016 SHALL, for nop, go T3->T0 with no strobes in T3.
REQ-017 SHALL, for halt, go T3->HALT with run=0; illegal=0.
REQ-018 SHALL, for undefined opcodes, go T3->HALT with run=0, illegal=1.
REQ-019 SHALL hold HALT until reset; mem_ready and ir are ignored in HALT.
REQ-020 SHALL drive gpr_in/gpr_out one-hot per ra/rb/rc index, including index 0 (bit 0).
REQ-021 SHALL decode ir only in T3 and later; ir changes in T0-T2 have no effect.

Reset
REQ-022 SHALL enter RESET on any edge with reset=1, from any state, including T1 wait and HALT; reset dominates mem_ready.
REQ-023 SHALL drive all strobes 0, gpr_in/gpr_out 16'h0000, alu_op 0000, run 0, illegal 0 in RESET.
REQ-024 SHALL go RESET->T0 on the first edge with reset=0.

Configuration
REQ-025 SHALL honour macro CONTROL_SEQUENCER_MULDIV_EN: defined -> mul/div execute T3 gpr_out[ra], y_in; T4 gpr_out[rb], z_in, alu_op Mul/Div; T5 z_low_out, lo_in; T6 z_high_out, hi_in; T6->T0.
REQ-026 SHALL, with CONTROL_SEQUENCER_MULDIV_EN undefined, treat opcodes 01110/01111 as undefined (REQ-018); T6 unreachable, hi_in/lo_in/z_high_out tied 0.
REQ-027 SHALL always tie hi_out, lo_out to 0.

Verification
REQ-028 SHALL cover: reset 1 cycle, mem_ready=1, ir=32'h4A920000 -> T0..T5 in 6 cycles; T3 gpr_out=16'h0004; T4 gpr_out=16'h0010, alu_op=0000, z_in=1; T5 gpr_in=16'h0020, z_low_out=1.
REQ-029 SHALL cover: mem_ready low 3 cycles in T1 -> T1 held 4 cycles, read=mdr_in=pc_in=1 throughout, then T2.
REQ-030 SHALL cover: ir=32'h5A900005 (addi R5,R2,5) -> T4 c_out=1, alu_op=0010; T5 gpr_in=16'h0020.
REQ-031 SHALL cover: ir=32'hD8000000 (halt) -> HALT after T3, run=0, illegal=0; ir=32'hF8000000 -> HALT, illegal=1.
REQ-032 SHALL cover: reset asserted during T4 -> next edge RESET, all outputs 0, then T0.
REQ-033 SHALL cover: ir=32'h71100000 (mul R2,R2) with macro defined -> T5 lo_in=1, T6 hi_in=1; macro undefined -> HALT, illegal=1.
